// File: rtl/refi_addr_gen.sv
// ---------------------------------------------------------------------------
// refi_addr_gen
//   Register-file port address generator for one DRRA cell. The sequencer
//   hands over one decoded REFI1+REFI2 config via valid/ready. The block then
//   emits one register-file address per active cycle. The pattern is built
//   from the start address, address count, step, initial delay, middle delay,
//   repetition count and repetition step. A done pulse marks the final
//   address.
//
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_cfg_valid           decoded config present
//   o_cfg_ready           block idle; config accepted on valid & ready
//   i_cfg_start           starting address
//   i_cfg_naddr           addresses per repetition minus 1
//   i_cfg_init_dly        idle cycles before the first address
//   i_cfg_step            step magnitude
//   i_cfg_step_neg        1 = subtract step
//   i_cfg_mid_dly         idle cycles between consecutive addresses
//   i_cfg_nrept           extra repetitions (0 = single pass)
//   i_cfg_rep_step        unsigned offset added to the repetition base
//   i_stall               freeze all state, suppress addr_en/done
//   o_addr_en             address valid this cycle
//   o_addr                register-file address (holds when not valid)
//   o_busy                generator active
//   o_done                one-cycle pulse with the final address
// ---------------------------------------------------------------------------
module refi_addr_gen #(
    parameter int ADDR_W  = 6,
    parameter int NADDR_W = 6,
    parameter int DLY_W   = 6,
    parameter int STEP_W  = 6,
    parameter int REPT_W  = 6,
    parameter int RSTEP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [ADDR_W-1:0]  i_cfg_start,
    input  logic [NADDR_W-1:0] i_cfg_naddr,
    input  logic [DLY_W-1:0]   i_cfg_init_dly,
    input  logic [STEP_W-1:0]  i_cfg_step,
    input  logic               i_cfg_step_neg,
    input  logic [DLY_W-1:0]   i_cfg_mid_dly,
    input  logic [REPT_W-1:0]  i_cfg_nrept,
    input  logic [RSTEP_W-1:0] i_cfg_rep_step,
    input  logic               i_stall,
    output logic               o_addr_en,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INIT_DLY = 2'd1,
        ST_EMIT     = 2'd2,
        ST_MID_DLY  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Captured configuration
    logic [NADDR_W-1:0] r_naddr;
    logic [STEP_W-1:0]  r_step;
    logic               r_step_neg;
    logic [DLY_W-1:0]   r_mid_dly;
    logic [REPT_W-1:0]  r_nrept;
    logic [RSTEP_W-1:0] r_rep_step;

    // Walk state: r_pend is the next address to emit, r_addr is what the
    // port shows (only updated when entering an emit cycle, so it holds the
    // last emitted value through delays and idle).
    logic [NADDR_W-1:0] r_k;
    logic [REPT_W-1:0]  r_rept;
    logic [DLY_W-1:0]   r_dly;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_pend;
    logic [ADDR_W-1:0]  r_addr;

    logic [NADDR_W-1:0] w_k_nxt;
    logic [REPT_W-1:0]  w_rept_nxt;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic [ADDR_W-1:0]  w_base_nxt;
    logic [ADDR_W-1:0]  w_pend_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [ADDR_W-1:0]  w_next_a;
    logic [ADDR_W-1:0]  w_step_addr;
    logic [ADDR_W-1:0]  w_rebase;
    logic               w_accept;
    logic               w_last_k;
    logic               w_last_r;
    logic               w_emit;

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_rept_nxt  = r_rept;
        w_dly_nxt   = r_dly;
        w_base_nxt  = r_base;
        w_pend_nxt  = r_pend;
        w_addr_nxt  = r_addr;
        w_next_a    = r_pend;

        w_accept    = (r_state == ST_IDLE) && i_cfg_valid;
        w_last_k    = (r_k == r_naddr);
        w_last_r    = (r_rept == r_nrept);
        w_emit      = (r_state == ST_EMIT) && !i_stall;
        // Address math wraps modulo 2**ADDR_W in both directions
        w_step_addr = r_step_neg ? (r_pend - ADDR_W'(r_step)) : (r_pend + ADDR_W'(r_step));
        w_rebase    = r_base + ADDR_W'(r_rep_step);

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_k_nxt    = '0;
                    w_rept_nxt = '0;
                    w_base_nxt = i_cfg_start;
                    w_pend_nxt = i_cfg_start;
                    if (i_cfg_init_dly != '0) begin
                        w_state_nxt = ST_INIT_DLY;
                        w_dly_nxt   = i_cfg_init_dly - DLY_W'(1);
                    end else begin
                        w_state_nxt = ST_EMIT;
                        w_addr_nxt  = i_cfg_start;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_INIT_DLY, ST_MID_DLY: begin
                if (i_stall) begin
                    w_state_nxt = r_state;
                end else if (r_dly == '0) begin
                    w_state_nxt = ST_EMIT;
                    w_addr_nxt  = r_pend;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            ST_EMIT: begin
                if (i_stall) begin
                    w_state_nxt = ST_EMIT;
                end else if (w_last_k && w_last_r) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Advance within the repetition or start the next one
                    if (w_last_k) begin
                        w_k_nxt    = '0;
                        w_rept_nxt = r_rept + REPT_W'(1);
                        w_base_nxt = w_rebase;
                        w_next_a   = w_rebase;
                    end else begin
                        w_k_nxt  = r_k + NADDR_W'(1);
                        w_next_a = w_step_addr;
                    end
                    w_pend_nxt = w_next_a;
                    if (r_mid_dly != '0) begin
                        w_state_nxt = ST_MID_DLY;
                        w_dly_nxt   = r_mid_dly - DLY_W'(1);
                    end else begin
                        w_state_nxt = ST_EMIT;
                        w_addr_nxt  = w_next_a;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration capture and address walk registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_naddr    <= '0;
            r_step     <= '0;
            r_step_neg <= 1'b0;
            r_mid_dly  <= '0;
            r_nrept    <= '0;
            r_rep_step <= '0;
            r_k        <= '0;
            r_rept     <= '0;
            r_dly      <= '0;
            r_base     <= '0;
            r_pend     <= '0;
            r_addr     <= '0;
        end else begin
            if (w_accept) begin
                r_naddr    <= i_cfg_naddr;
                r_step     <= i_cfg_step;
                r_step_neg <= i_cfg_step_neg;
                r_mid_dly  <= i_cfg_mid_dly;
                r_nrept    <= i_cfg_nrept;
                r_rep_step <= i_cfg_rep_step;
            end
            r_k    <= w_k_nxt;
            r_rept <= w_rept_nxt;
            r_dly  <= w_dly_nxt;
            r_base <= w_base_nxt;
            r_pend <= w_pend_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    // Stall must silence the port in the same cycle, so enable and done are
    // gated directly from the state register.
    assign o_addr_en   = w_emit;
    assign o_done      = w_emit && w_last_k && w_last_r;
    assign o_addr      = r_addr;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_cfg_ready = (r_state == ST_IDLE);

endmodule
